div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares one divide_by_subtraction unit among N_REQ requesters in the CRT decryption path: qinv extended-Euclid step, h reduction, d mod (p-1), d mod (q-1).
- Arbitrates round-robin, launches the divider and waits for done with a watchdog.
- Routes quotient/remainder back to the winning requester.
- Intercepts divide-by-zero so the divider never sees a zero divisor.

Parameters:
- W, 512, operand/result width in bits.
- N_REQ, 4, number of requesters.
- TIMEOUT, 65535, max cycles waiting for div_done before error response; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  requester i has an operation pending
- req_dividend  in  N_REQ*W  flattened dividends, slice i = bits [i*W +: W]
- req_divisor  in  N_REQ*W  flattened divisors, same slicing
- req_ready  out  N_REQ  one-hot pulse: request i accepted this cycle
- resp_valid  out  N_REQ  one-hot pulse: result for requester i valid this cycle
- resp_quot  out  W  quotient (shared bus, valid with resp_valid)
- resp_rem  out  W  remainder (shared bus)
- resp_err  out  1  1 = divide-by-zero or timeout (valid with resp_valid)
- busy  out  1  high in any state except IDLE
- div_start  out  1  divider start pulse
- div_dividend  out  W  registered operand to divider
- div_divisor  out  W  registered operand to divider
- div_quot  in  W  divider outputcount
- div_rem  in  W  divider remainder
- div_done  in  1  divider done

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, watchdog count=0. Reset mid-operation aborts with no resp_valid. A later div_done is ignored until the next LAUNCH.
- States are IDLE, LAUNCH, BLANK, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Pulse req_ready[g] and latch g, dividend and divisor.
  - If divisor==0: next RESP with quot = all ones, rem = dividend, err=1; divider untouched.
  - Else: next LAUNCH.
- LAUNCH: div_start=1 for exactly one cycle; div_dividend/div_divisor already stable from the latch. Next BLANK.
- BLANK: one cycle; div_done is ignored so that a stale done from a previous op cannot complete this one. Next WAIT.
- WAIT:
  - On div_done=1: latch div_quot and div_rem, err=0, next RESP.
  - Watchdog counts WAIT cycles. When count reaches TIMEOUT (if nonzero): quot=0, rem=0, err=1, next RESP.
- RESP: resp_valid[g]=1 for one cycle with quot/rem/err. Set rr_ptr=(g+1) mod N_REQ. Next IDLE.
- Latency, normal op:
  - req_ready occurs in the first cycle req_valid is sampled while IDLE.
  - resp_valid occurs 4 + D cycles later, where D = WAIT cycles until div_done (D≥1).
  - Divide-by-zero: resp_valid 1 cycle after req_ready.
- Requester handshake:
  - Hold req_valid and operands stable until req_ready.
  - May deassert valid freely before acceptance.
  - Operand changes after acceptance have no effect.
- Requests arriving while busy wait; there is no queueing beyond the requester's held valid.
- Simultaneous requests: rr_ptr priority. After grant g, requester g has the lowest priority next time, so no requester starves.
- A single requester issuing back-to-back requests is granted every op; IDLE occupies one cycle between ops.
- resp_quot/resp_rem/resp_err hold their last values outside RESP; only resp_valid qualifies them.
- Arithmetic: no width change; operands pass through unmodified.
- W-bit buses are registered (no combinational path from req_* to div_*).

Decomposition:
- Package div_share_pkg holds:
  - the state enum (IDLE, LAUNCH, BLANK, WAIT, RESP);
  - localparam PTR_W = clog2(N_REQ);
  - TO_W watchdog width.
- One sub-module: rr_pick, a combinational round-robin priority picker (req vector and rr_ptr in, one-hot grant plus index out). Reusable by later modexp schedulers.
- The divider itself stays outside; this block connects to one divide_by_subtraction instance.

Test Plan:
- Single requester 1, dividend=1024, divisor=88; divider model done after 10 cycles:
  - div_start pulses once;
  - resp_valid=4'b0010 with quot=11, rem=56, err=0;
  - latency from req_ready = 4+10 cycles.
- All four valid together from reset, each with distinct operands (e.g. 1024/52 → quot 19, rem 36):
  - grants occur in order 0,1,2,3;
  - each response goes to the correct index with correct values.
- Requester 2 divisor=0, dividend=77:
  - no div_start;
  - resp_valid[2] one cycle after req_ready with quot=all ones, rem=77, err=1.
- TIMEOUT=20, divider model never asserts done:
  - resp_err=1 with quot=0, rem=0 after 20 WAIT cycles;
  - the next request then completes normally.
- Divider model asserts div_done in the BLANK cycle and again 5 cycles later:
  - the first done is ignored;
  - the result is latched from the second.
- rst asserted during WAIT:
  - busy=0 and rr_ptr=0 on the next cycle;
  - no resp_valid;
  - a late div_done in IDLE produces no response.

Source files
------------

// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared state type and width helpers for the divider-sharing arbiter
package div_share_pkg;

    typedef enum logic [2:0] {IDLE, LAUNCH, BLANK, WAIT, RESP} state_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_REQ_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 65535;
    localparam int PTR_W           = width_of(N_REQ_DEFAULT);
    localparam int TO_W            = width_of(TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/div_share_arbiter_rr_pick.sv
// rtl/div_share_arbiter_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick
    import div_share_pkg::*;
#(
    parameter int N  = N_REQ_DEFAULT,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0]   sum;
    logic [PW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            j = sum[PW-1:0];
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = j;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one external divider among N_REQ requesters
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int W       = 512,
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_dividend,
    input  logic [N_REQ*W-1:0] req_divisor,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_quot,
    output logic [W-1:0]       resp_rem,
    output logic               resp_err,
    output logic               busy,
    output logic               div_start,
    output logic [W-1:0]       div_dividend,
    output logic [W-1:0]       div_divisor,
    input  logic [W-1:0]       div_quot,
    input  logic [W-1:0]       div_rem,
    input  logic               div_done
);

    localparam int PW = width_of(N_REQ);
    localparam int TW = width_of(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t         state;
    logic [PW-1:0]  rr_ptr;
    logic [PW-1:0]  gnt_idx;
    logic [TW-1:0]  wd;
    logic           done_seen;
    logic [W-1:0]   res_quot;
    logic [W-1:0]   res_rem;
    logic           res_err;

    logic [N_REQ-1:0] pick_grant;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [W-1:0]     sel_dividend;
    logic [W-1:0]     sel_divisor;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign sel_dividend = req_dividend[int'(pick_idx) * W +: W];
    assign sel_divisor  = req_divisor[int'(pick_idx) * W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
            wd           <= '0;
            done_seen    <= 1'b0;
            res_quot     <= '0;
            res_rem      <= '0;
            res_err      <= 1'b0;
            req_ready    <= '0;
            resp_valid   <= '0;
            resp_quot    <= '0;
            resp_rem     <= '0;
            resp_err     <= 1'b0;
            busy         <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            div_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        req_ready <= pick_grant;
                        gnt_idx   <= pick_idx;
                        busy      <= 1'b1;
                        // A zero divisor is answered locally; the divider never sees it.
                        if (sel_divisor == '0) begin
                            res_quot <= '1;
                            res_rem  <= sel_dividend;
                            res_err  <= 1'b1;
                            state    <= RESP;
                        end else begin
                            div_dividend <= sel_dividend;
                            div_divisor  <= sel_divisor;
                            div_start    <= 1'b1;
                            state        <= LAUNCH;
                        end
                    end
                end
                LAUNCH: state <= BLANK;
                BLANK: begin
                    wd        <= '0;
                    done_seen <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // The result is captured one cycle before completing so the wide buses settle.
                    if (done_seen) begin
                        state <= RESP;
                    end else if (div_done) begin
                        res_quot  <= div_quot;
                        res_rem   <= div_rem;
                        res_err   <= 1'b0;
                        done_seen <= 1'b1;
                    end else if (TIMEOUT != 0 && wd == TO_LAST) begin
                        res_quot <= '0;
                        res_rem  <= '0;
                        res_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= N_REQ'(1) << gnt_idx;
                    resp_quot  <= res_quot;
                    resp_rem   <= res_rem;
                    resp_err   <= res_err;
                    rr_ptr     <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - scoreboard bench for div_share_arbiter with a behavioural divider
module tb_div_share_arbiter;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int TO = 20;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_quot;
    logic [W-1:0]   resp_rem;
    logic           resp_err;
    logic           busy;
    logic           div_start;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [W-1:0]   div_quot;
    logic [W-1:0]   div_rem;
    logic           div_done;

    div_share_arbiter #(.W(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_quot    (resp_quot),
        .resp_rem     (resp_rem),
        .resp_err     (resp_err),
        .busy         (busy),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quot     (div_quot),
        .div_rem      (div_rem),
        .div_done     (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_cyc = 0;
    int   starts = 0;

    // Divider model: done is high in the wait_cycles-th WAIT cycle after a start.
    int           wait_cycles = 3;
    bit           stale_en = 1'b0;
    int           m_cnt = 0;
    bit           m_on = 1'b0;
    logic [W-1:0] m_a, m_b;

    initial begin
        div_done = 1'b0;
        div_quot = '0;
        div_rem  = '0;
    end

    always @(negedge clk) begin
        if (div_start) begin
            m_a   = div_dividend;
            m_b   = div_divisor;
            m_cnt = 0;
            m_on  = 1'b1;
        end else if (m_on) begin
            m_cnt++;
        end
        div_done = 1'b0;
        if (m_on && stale_en && m_cnt == 1) begin
            div_done = 1'b1;
            div_quot = 64'hDEAD;
            div_rem  = 64'hBEEF;
        end
        if (m_on && wait_cycles >= 0 && m_cnt == wait_cycles + 1) begin
            div_done = 1'b1;
            div_quot = m_a / m_b;
            div_rem  = m_a % m_b;
            m_on     = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        cyc++;
        if (div_start) starts++;
        if (req_ready != '0) begin
            rdy_cyc = cyc;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    req_valid[i] = 1'b0;
                    grants.push_back(i);
                end
            end
        end
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
        req_valid[i]           = 1'b1;
        e.idx = i;
        if (b == '0) begin
            e.quot = '1;
            e.rem  = a;
            e.err  = 1'b1;
        end else begin
            e.quot = a / b;
            e.rem  = a % b;
            e.err  = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic wait_resp(input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (resp_valid != '0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || busy !== 1'b0 || div_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b start=%b, want all 0", req_ready, resp_valid, busy, div_start);
        end
        checks++;
        if (resp_quot !== '0 || resp_rem !== '0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got quot=%h rem=%h err=%b, want 0", resp_quot, resp_rem, resp_err);
        end
        checks++;
        if (div_dividend !== '0 || div_divisor !== '0) begin
            errors++;
            $display("FAIL reset_div: got dividend=%h divisor=%h, want 0", div_dividend, div_divisor);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_all_four();
        bit got;
        exp_t e;
        logic [N-1:0] ev;
        grants.delete();
        wait_cycles = 3;
        post(0, 1024, 52);
        post(1, 5000, 7);
        post(2, 999, 1000);
        post(3, 65535, 255);
        for (int r = 0; r < N; r++) begin
            wait_resp(40, got);
            checks++;
            if (!got || sb.size() == 0) begin
                errors++;
                $display("FAIL all_four_resp%0d: got no response within budget, want one", r);
            end else begin
                e = sb.pop_front();
                ev = N'(1) << e.idx;
                if (resp_valid !== ev || resp_quot !== e.quot || resp_rem !== e.rem || resp_err !== e.err) begin
                    errors++;
                    $display("FAIL all_four_resp%0d: got valid=%b quot=%h rem=%h err=%b, want valid=%b quot=%h rem=%h err=%b",
                             r, resp_valid, resp_quot, resp_rem, resp_err, ev, e.quot, e.rem, e.err);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (i >= grants.size() || grants[i] != i) begin
                errors++;
                $display("FAIL all_four_grant%0d: got %0d, want %0d", i, (i < grants.size()) ? grants[i] : -1, i);
            end
        end
    endtask

    task automatic test_single();
        bit got;
        exp_t e;
        starts = 0;
        wait_cycles = 10;
        post(1, 1024, 88);
        wait_resp(40, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL single_resp: got no response within budget, want one");
        end else begin
            e = sb.pop_front();
            if (resp_valid !== 4'b0010 || resp_quot !== 64'd11 || resp_rem !== 64'd56 || resp_err !== 1'b0
                || e.quot !== 64'd11 || e.rem !== 64'd56) begin
                errors++;
                $display("FAIL single_resp: got valid=%b quot=%0d rem=%0d err=%b, want valid=0010 quot=11 rem=56 err=0",
                         resp_valid, resp_quot, resp_rem, resp_err);
            end
        end
        checks++;
        if (cyc - rdy_cyc != 14) begin
            errors++;
            $display("FAIL single_latency: got %0d, want 14", cyc - rdy_cyc);
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL single_starts: got %0d, want 1", starts);
        end
    endtask

    task automatic test_div_zero();
        bit got;
        exp_t e;
        starts = 0;
        post(2, 77, 0);
        wait_resp(20, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL divzero_resp: got no response within budget, want one");
        end else begin
            e = sb.pop_front();
            if (resp_valid !== 4'b0100 || resp_quot !== e.quot || resp_rem !== 64'd77 || resp_err !== 1'b1) begin
                errors++;
                $display("FAIL divzero_resp: got valid=%b quot=%h rem=%0d err=%b, want valid=0100 quot=%h rem=77 err=1",
                         resp_valid, resp_quot, resp_rem, resp_err, e.quot);
            end
        end
        checks++;
        if (cyc - rdy_cyc != 1) begin
            errors++;
            $display("FAIL divzero_latency: got %0d, want 1", cyc - rdy_cyc);
        end
        checks++;
        if (starts != 0) begin
            errors++;
            $display("FAIL divzero_starts: got %0d, want 0", starts);
        end
    endtask

    task automatic test_timeout();
        bit got;
        exp_t e;
        wait_cycles = -1;
        post(0, 100, 7);
        void'(sb.pop_back());
        sb.push_back('{idx: 0, quot: '0, rem: '0, err: 1'b1});
        wait_resp(60, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout_resp: got no response within budget, want error response");
        end else begin
            e = sb.pop_front();
            if (resp_valid !== 4'b0001 || resp_quot !== e.quot || resp_rem !== e.rem || resp_err !== e.err) begin
                errors++;
                $display("FAIL timeout_resp: got valid=%b quot=%h rem=%h err=%b, want valid=0001 quot=0 rem=0 err=1",
                         resp_valid, resp_quot, resp_rem, resp_err);
            end
        end
        checks++;
        if (got && cyc - rdy_cyc < TO) begin
            errors++;
            $display("FAIL timeout_early: got latency %0d, want at least %0d", cyc - rdy_cyc, TO);
        end
        wait_cycles = 2;
        post(0, 300, 17);
        wait_resp(30, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL after_timeout_resp: got no response within budget, want one");
        end else begin
            e = sb.pop_front();
            if (resp_valid !== 4'b0001 || resp_quot !== 64'd17 || resp_rem !== 64'd11 || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL after_timeout_resp: got valid=%b quot=%0d rem=%0d err=%b, want valid=0001 quot=17 rem=11 err=0",
                         resp_valid, resp_quot, resp_rem, resp_err);
            end
        end
    endtask

    task automatic test_stale_done();
        bit got;
        exp_t e;
        stale_en = 1'b1;
        wait_cycles = 5;
        post(2, 4000, 9);
        wait_resp(30, got);
        stale_en = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stale_resp: got no response within budget, want one");
        end else begin
            e = sb.pop_front();
            if (resp_valid !== 4'b0100 || resp_quot !== 64'd444 || resp_rem !== 64'd4 || resp_err !== e.err) begin
                errors++;
                $display("FAIL stale_resp: got valid=%b quot=%0d rem=%0d err=%b, want valid=0100 quot=444 rem=4 err=0",
                         resp_valid, resp_quot, resp_rem, resp_err);
            end
        end
        checks++;
        if (cyc - rdy_cyc != 9) begin
            errors++;
            $display("FAIL stale_latency: got %0d, want 9", cyc - rdy_cyc);
        end
    endtask

    task automatic test_reset_mid_op();
        bit got;
        int stray;
        exp_t e;
        grants.delete();
        wait_cycles = 10;
        post(1, 1024, 88);
        for (int k = 0; k < 10 && grants.size() == 0; k++) step();
        checks++;
        if (grants.size() == 0) begin
            errors++;
            $display("FAIL midreset_grant: got no grant within budget, want grant 1");
        end
        repeat (3) step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || resp_valid !== '0 || div_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b valid=%b start=%b, want 0", busy, resp_valid, div_start);
        end
        rst = 1'b0;
        sb.delete();
        stray = 0;
        repeat (15) begin
            step();
            if (resp_valid != '0 || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL midreset_late_done: got %0d active cycles, want 0", stray);
        end
        grants.delete();
        wait_cycles = 1;
        post(0, 50, 5);
        post(3, 51, 5);
        for (int r = 0; r < 2; r++) begin
            wait_resp(30, got);
            checks++;
            if (!got || sb.size() == 0) begin
                errors++;
                $display("FAIL midreset_resp%0d: got no response within budget, want one", r);
            end else begin
                e = sb.pop_front();
                if (resp_valid !== (N'(1) << e.idx) || resp_quot !== e.quot || resp_rem !== e.rem || resp_err !== e.err) begin
                    errors++;
                    $display("FAIL midreset_resp%0d: got valid=%b quot=%0d rem=%0d err=%b, want idx=%0d quot=%0d rem=%0d err=%b",
                             r, resp_valid, resp_quot, resp_rem, resp_err, e.idx, e.quot, e.rem, e.err);
                end
            end
        end
        checks++;
        if (grants.size() != 2 || grants[0] != 0 || grants[1] != 3) begin
            errors++;
            $display("FAIL midreset_order: got first grant %0d of %0d, want 0 then 3",
                     (grants.size() > 0) ? grants[0] : -1, grants.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        test_reset();
        test_all_four();
        test_single();
        test_div_zero();
        test_timeout();
        test_stale_done();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
